// File: rtl/dla_cdc_handshake_arbiter.sv
// ---------------------------------------------------------------------------
// dla_cdc_handshake_arbiter
//
// Source-side controller that shares one 4-phase req/ack clock-crossing
// channel between NUM_REQ requesters. It grants requesters round-robin and
// keeps one transfer in flight at a time. The payload register stays
// constant for the whole handshake, so the external synchronizers see
// stable data.
//
// Ports:
//   clk          rising-edge clock
//   i_reset      synchronous active-high reset
//   i_valid      per-requester request, held until the matching o_ready
//   i_data       packed payloads, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_ready      one-hot 1-cycle pulse when a payload is captured
//   o_done       one-hot 1-cycle pulse when the handshake has completed
//   o_xfer_req   registered req level toward the destination domain
//   o_xfer_data  registered payload, stable while a transfer is in flight
//   i_xfer_ack   ack level, already synchronized into clk
//   o_busy       high whenever a transfer is in progress
//   o_error      1-cycle ack-timeout pulse (0 when the timeout is not built)
//
// Optional feature: define DLA_CDC_HANDSHAKE_ARB_TIMEOUT_EN to add an ack
// watchdog of TIMEOUT_CYCLES cycles in REQ and WAIT_LOW.
// ---------------------------------------------------------------------------
module dla_cdc_handshake_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic [NUM_REQ-1:0]            o_ready,
  output logic [NUM_REQ-1:0]            o_done,
  output logic                          o_xfer_req,
  output logic [DATA_WIDTH-1:0]         o_xfer_data,
  input  logic                          i_xfer_ack,
  output logic                          o_busy,
  output logic                          o_error
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LAST_I = NUM_REQ - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = LAST_I[IDX_W-1:0];
  localparam logic [IDX_W:0]   NREQ     = NUM_REQ[IDX_W:0];

  generate
    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 4) begin : g_param_check
      $error("dla_cdc_handshake_arbiter: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      ptr_nxt;
  logic [IDX_W-1:0]      cur;
  logic [IDX_W-1:0]      gnt_off;
  logic [IDX_W-1:0]      gnt_idx;
  logic [IDX_W:0]        gnt_sum;
  logic [IDX_W:0]        gnt_wrap;
  logic [2*NUM_REQ-1:0]  vld_rot;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  gnt_found;
  logic                  grant_en;
  logic                  timeout_fire;
  logic                  xfer_req_q;
  logic [DATA_WIDTH-1:0] xfer_data_q;
  logic [NUM_REQ-1:0]    done_q;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (idx == IDX_W'(k)) v[k] = 1'b1;
    end
    return v;
  endfunction

  // Rotate the request vector so the pointer position lands at bit 0; the
  // lowest set bit of the rotated vector is then the round-robin winner.
  assign vld_rot = {i_valid, i_valid} >> ptr;

  always_comb begin
    gnt_found = 1'b0;
    gnt_off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (vld_rot[i]) begin
        gnt_found = 1'b1;
        gnt_off   = IDX_W'(i);
      end
    end
  end

  assign gnt_sum  = {1'b0, ptr} + {1'b0, gnt_off};
  assign gnt_wrap = gnt_sum - NREQ;
  assign gnt_idx  = (gnt_sum >= NREQ) ? gnt_wrap[IDX_W-1:0] : gnt_sum[IDX_W-1:0];
  assign ptr_nxt  = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_idx == IDX_W'(k)) gnt_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Any ack seen while idle belongs to an earlier (possibly abandoned)
  // transfer, so no grant is issued until the ack level has returned low.
  assign grant_en = (state == IDLE) && gnt_found && !i_xfer_ack && !i_reset;
  assign o_ready  = grant_en ? onehot(gnt_idx) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (grant_en) state_nxt = REQ;
      REQ:      if (i_xfer_ack) state_nxt = WAIT_LOW;
                else if (timeout_fire) state_nxt = IDLE;
      WAIT_LOW: if (!i_xfer_ack || timeout_fire) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state       <= IDLE;
      ptr         <= '0;
      cur         <= '0;
      xfer_req_q  <= 1'b0;
      xfer_data_q <= '0;
      done_q      <= '0;
    end else begin
      state      <= state_nxt;
      xfer_req_q <= (state_nxt == REQ);
      done_q     <= '0;
      if (grant_en) begin
        xfer_data_q <= gnt_data;
        cur         <= gnt_idx;
        ptr         <= ptr_nxt;
      end
      if (state == WAIT_LOW && !i_xfer_ack) done_q <= onehot(cur);
    end
  end

`ifdef DLA_CDC_HANDSHAKE_ARB_TIMEOUT_EN
  localparam int CNT_W   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int TO_LAST_I = TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];

  logic [CNT_W-1:0] to_cnt;
  logic             error_q;

  // The counter is zero on the first cycle of REQ / WAIT_LOW, so it fires
  // on that state's TIMEOUT_CYCLES-th cycle. A normal exit in the same
  // cycle takes priority over the timeout.
  assign timeout_fire = (to_cnt == TO_LAST) &&
                        ((state == REQ && !i_xfer_ack) ||
                         (state == WAIT_LOW && i_xfer_ack));

  always_ff @(posedge clk) begin
    if (i_reset) begin
      to_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      error_q <= timeout_fire;
      if (state_nxt != state) to_cnt <= '0;
      else if (state != IDLE) to_cnt <= to_cnt + 1'b1;
    end
  end

  assign o_error = error_q;
`else
  assign timeout_fire = 1'b0;
  assign o_error      = 1'b0;
`endif

  assign o_xfer_req  = xfer_req_q;
  assign o_xfer_data = xfer_data_q;
  assign o_done      = done_q;
  assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_dla_cdc_handshake_arbiter.sv
module tb_dla_cdc_handshake_arbiter;
  localparam int N      = 4;
  localparam int DW     = 32;
  localparam int TO_CYC = 8;
`ifdef DLA_CDC_HANDSHAKE_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    valid;
  logic [N*DW-1:0] data;
  logic            ack;
  logic [N-1:0]    o_ready;
  logic [N-1:0]    o_done;
  logic            o_xfer_req;
  logic [DW-1:0]   o_xfer_data;
  logic            o_busy;
  logic            o_error;

  always #5 clk = ~clk;

  dla_cdc_handshake_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .i_reset(rst), .i_valid(valid), .i_data(data),
    .o_ready(o_ready), .o_done(o_done), .o_xfer_req(o_xfer_req),
    .o_xfer_data(o_xfer_data), .i_xfer_ack(ack), .o_busy(o_busy),
    .o_error(o_error)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return 0;
  endfunction

  // Destination-side ack: echoes req after ack_dly cycles, or a forced level.
  logic [15:0]  hist;
  int           ack_dly;
  bit           ack_force_en;
  logic         ack_force;
  bit           rand_en;
  logic [N-1:0] ready_seen;

  // Transaction-level reference: phase 0 idle, 1 waiting for ack high,
  // 2 waiting for ack low.
  int            m_phase, m_owner, m_rr, m_cnt, g;
  logic [DW-1:0] m_data;
  logic [N-1:0]  m_done, e_rdy;
  logic          m_err;
  bit            chk_en;

  always @(negedge clk) begin
    e_rdy = '0;
    g     = -1;
    if (!rst && m_phase == 0 && !ack)
      for (int i = 0; i < N; i++)
        if (g < 0 && valid[(m_rr + i) % N]) g = (m_rr + i) % N;
    if (g >= 0) e_rdy[g] = 1'b1;
    if (chk_en) begin
      chk("ready", o_ready, e_rdy);
      chk("xfer_req", o_xfer_req, m_phase == 1);
      chk("xfer_data", o_xfer_data, m_data);
      chk("busy", o_busy, m_phase != 0);
      chk("done", o_done, m_done);
      chk("error", o_error, m_err);
    end
    ready_seen = o_ready;
    if (rst) begin
      m_phase = 0; m_rr = 0; m_owner = 0; m_cnt = 0;
      m_data = '0; m_done = '0; m_err = 1'b0;
    end else begin
      m_done = '0;
      m_err  = 1'b0;
      case (m_phase)
        0: if (g >= 0) begin
             m_phase = 1; m_owner = g; m_rr = (g + 1) % N; m_cnt = 0;
             m_data  = data[g*DW +: DW];
           end
        1: if (ack) begin m_phase = 2; m_cnt = 0; end
           else if (TO_EN && m_cnt == TO_CYC - 1) begin m_phase = 0; m_err = 1'b1; end
           else m_cnt++;
        default: if (!ack) begin m_phase = 0; m_done[m_owner] = 1'b1; end
           else if (TO_EN && m_cnt == TO_CYC - 1) begin m_phase = 0; m_err = 1'b1; end
           else m_cnt++;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    valid = valid & ~ready_seen;
    hist  = {hist[14:0], o_xfer_req};
    ack   = ack_force_en ? ack_force : hist[ack_dly];
    if (rand_en) begin
      for (int k = 0; k < N; k++) begin
        if (!valid[k] && $urandom_range(0, 3) == 0) begin
          valid[k] = 1'b1;
          data[k*DW +: DW] = $urandom;
        end else if (valid[k] && $urandom_range(0, 31) == 0) begin
          valid[k] = 1'b0;
        end
      end
      rst = ($urandom_range(0, 299) == 0);
      if (!o_busy && $urandom_range(0, 15) == 0) ack_dly = $urandom_range(1, 4);
    end
  endtask

  task automatic do_reset(input int n);
    rst   = 1'b1;
    valid = '0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && o_busy; i++) tick();
    chk("wait_idle", o_busy, 1'b0);
  endtask

  task automatic collect(input logic [N-1:0] v, input bit hold, input int ngr,
                         output logic [31:0] seq, output int cnt);
    seq   = '0;
    cnt   = 0;
    valid = valid | v;
    for (int i = 0; i < 300 && cnt < ngr; i++) begin
      @(negedge clk);
      if (o_ready != '0) begin
        seq = {seq[27:0], 4'(oh2i(o_ready))};
        cnt++;
      end
      tick();
      if (hold) valid = v;
    end
  endtask

  logic [31:0] seq;
  int          cnt, n_done, t0, te, t1;

  initial begin
    rst = 1'b1; valid = '0; data = '0; ack = 1'b0; hist = '0;
    ack_dly = 3; ack_force_en = 1'b0; ack_force = 1'b0; rand_en = 1'b0;
    ready_seen = '0; chk_en = 1'b0;
    m_phase = 0; m_owner = 0; m_rr = 0; m_cnt = 0; g = -1;
    m_data = '0; m_done = '0; m_err = 1'b0; e_rdy = '0;

    repeat (3) tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_req", o_xfer_req, 1'b0);
    chk("rst_data", o_xfer_data, 32'h0);

    // Single transfer, ack 3 cycles after req.
    tick();
    rst = 1'b0;
    valid = 4'b0001;
    data[0 +: DW] = 32'hDEADBEEF;
    @(negedge clk);
    chk("s1_ready_t0", o_ready, 4'b0001);
    tick();
    @(negedge clk);
    chk("s1_req_t1", o_xfer_req, 1'b1);
    chk("s1_data_t1", o_xfer_data, 32'hDEADBEEF);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clk);
      if (o_done[0]) n_done++;
      if (n_done == 0) chk("s1_data_hold", o_xfer_data, 32'hDEADBEEF);
    end
    chk("s1_done_once", n_done, 1);

    // All four requesting, ack echoes req after 2 cycles.
    ack_dly = 2;
    do_reset(6);
    collect(4'b1111, 1'b1, 5, seq, cnt);
    chk("s2_grant_count", cnt, 5);
    chk("s2_order", seq[19:0], 20'h01230);
    valid = '0;
    wait_idle();

    // Pointer at 3 (after granting 2), then requesters 1 and 3.
    do_reset(6);
    collect(4'b0100, 1'b0, 1, seq, cnt);
    chk("s3_first", seq[3:0], 4'h2);
    collect(4'b1010, 1'b0, 2, seq, cnt);
    chk("s3_count", cnt, 2);
    chk("s3_order", seq[7:0], 8'h31);
    wait_idle();

    // Stale ack held through the end of reset.
    ack_force_en = 1'b1;
    ack_force    = 1'b1;
    do_reset(4);
    valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s4_no_ready", o_ready, 4'b0000);
      tick();
    end
    ack_force = 1'b0;
    ack       = 1'b0;
    @(negedge clk);
    chk("s4_ready", o_ready, 4'b0100);
    ack_force_en = 1'b0;
    tick();
    wait_idle();

    // Reset while in REQ: req drops, no done, pointer back to 0.
    ack_dly = 4;
    collect(4'b0100, 1'b0, 1, seq, cnt);
    rst = 1'b1;
    @(negedge clk);
    chk("s5_req_before", o_xfer_req, 1'b1);
    tick();
    @(negedge clk);
    chk("s5_req_after", o_xfer_req, 1'b0);
    chk("s5_busy_after", o_busy, 1'b0);
    chk("s5_no_done", o_done, 4'b0000);
    repeat (6) tick();
    rst = 1'b0;
    collect(4'b1001, 1'b0, 1, seq, cnt);
    chk("s5_count", cnt, 1);
    chk("s5_ptr0", seq[3:0], 4'h0);
    valid = '0;
    wait_idle();

`ifdef DLA_CDC_HANDSHAKE_ARB_TIMEOUT_EN
    // Ack never returns: timeout, then the next requester is granted.
    ack_force_en = 1'b1;
    ack_force    = 1'b0;
    do_reset(4);
    valid = 4'b0011;
    t0 = -1; te = -1; t1 = -1; n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_ready[0] && t0 < 0) t0 = i;
      if (o_error && te < 0) te = i;
      if (o_ready[1] && t1 < 0) t1 = i;
      if (o_done != '0) n_done++;
      tick();
    end
    chk("s6_err_latency", te - t0, 9);
    chk("s6_next_grant", t1 - te, 0);
    chk("s6_no_done", n_done, 0);
    ack_force_en = 1'b0;
    do_reset(6);
`endif

    // Randomized traffic against the reference model.
    rand_en = 1'b1;
    repeat (3000) tick();
    rand_en = 1'b0;
    rst     = 1'b0;
    valid   = '0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dla_cdc_handshake_arbiter.md
Name: dla_cdc_handshake_arbiter

Overview:
- Single-clock source-side controller that shares one 4-phase req/ack clock-crossing channel between NUM_REQ requesters.
- The level o_xfer_req and the bus o_xfer_data leave this block through external full synchronizers into the destination domain.
- The destination's ack level returns through a full synchronizer as i_xfer_ack, already in the clk domain.
- Round-robin arbitration; one transfer in flight at a time; data held stable for the whole handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, payload width per requester.
- TIMEOUT_CYCLES, 1024, ack wait limit in cycles; used only with the optional feature (>=4).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- i_reset  input  1  synchronous reset, active-high.
- i_valid  input  NUM_REQ  per-requester request; held until the matching o_ready.
- i_data  input  NUM_REQ*DATA_WIDTH  payloads; requester k uses bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_ready  output  NUM_REQ  one-hot, 1-cycle pulse when a payload is captured.
- o_done  output  NUM_REQ  one-hot, 1-cycle pulse when that requester's transfer has completed the 4-phase handshake.
- o_xfer_req  output  1  level to the destination; registered output, no combinational path.
- o_xfer_data  output  DATA_WIDTH  registered payload; constant while o_xfer_req=1 or state is WAIT_LOW.
- i_xfer_ack  input  1  synchronized ack level from the destination.
- o_busy  output  1  high whenever state != IDLE.
- o_error  output  1  1-cycle timeout pulse; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset, synchronous while i_reset=1:
  - state=IDLE, o_xfer_req=0, o_xfer_data=0, o_ready=0, o_done=0, o_busy=0, o_error=0.
  - Round-robin pointer=0, so requester 0 has highest priority first.
  - Reset mid-transfer drops o_xfer_req next cycle. The destination must tolerate an abandoned request.
- States: IDLE -> REQ -> WAIT_LOW -> IDLE.
- IDLE:
  - If any i_valid is set, grant the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Same cycle: pulse o_ready[g], register o_xfer_data=i_data[g], store g.
  - Next state REQ; o_xfer_req=1 from the next cycle.
  - Pointer becomes (g+1) mod NUM_REQ.
- IDLE entry guard: if i_xfer_ack=1 on IDLE entry (stale ack), grant is suppressed until i_xfer_ack=0.
- REQ: hold o_xfer_req=1. On i_xfer_ack=1, deassert o_xfer_req next cycle and enter WAIT_LOW.
- WAIT_LOW: o_xfer_req=0. On i_xfer_ack=0, pulse o_done[g] and return to IDLE.
- Back-to-back: a new grant is allowed in the same cycle o_done pulses, since the state is IDLE from that cycle's evaluation. Minimum transfer period is therefore 4 cycles plus round-trip synchronizer latency.
- Simultaneous requests: exactly one grant per IDLE cycle. Ungranted requesters keep i_valid high and are not acknowledged.
- A requester deasserting i_valid before o_ready is legal; it loses its slot with no side effects.
- i_valid changes while busy are ignored until IDLE.
- o_ready and o_done are never asserted for more than one requester in the same cycle. o_done[g] never precedes o_ready[g].
- Latency from i_valid to o_xfer_req rising: 1 cycle when idle and i_xfer_ack=0.

Optional Feature:
- Macro: DLA_CDC_HANDSHAKE_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ or WAIT_LOW and increments each cycle in those states.
  - Reaching TIMEOUT_CYCLES in REQ or WAIT_LOW: pulse o_error, force o_xfer_req=0, go to IDLE without o_done.
  - The stale-ack guard still applies afterwards.
- Not defined: no counter; o_error constant 0; the block waits indefinitely on i_xfer_ack.

Test Plan:
- Reset, then i_valid=4'b0001 with data0=0xDEADBEEF, and ack returned 3 cycles after req -> o_ready[0] at T0, o_xfer_req high at T0+1, o_xfer_data=0xDEADBEEF stable until o_done[0], and o_done[0] exactly once.
- i_valid=4'b1111 held, ack model echoes req with 2-cycle delay -> grant order 0,1,2,3,0. Each o_done precedes the next o_ready; no two grants overlap.
- i_valid=4'b1010 with pointer=3 -> requester 3 is granted first, then 1.
- i_xfer_ack held 1 at end of reset while i_valid[2]=1 -> no o_ready until ack is 0, then grant to requester 2 the next cycle.
- i_reset asserted while in REQ -> o_xfer_req=0 and o_busy=0 the cycle after, no o_done. After release, pointer=0.
- With DLA_CDC_HANDSHAKE_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, ack never returns -> o_error pulse 8 cycles after REQ entry, o_xfer_req drops, no o_done, and the next requester is granted.
